// File: rtl/cgra_mem_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite master port between per-node
// read and write engines, running exactly one AXI transaction at a time.
module cgra_mem_arbiter #(
  parameter int NUM_READ   = 4,
  parameter int NUM_WRITE  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_READ-1:0]             rd_req_i,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr_i,
  output logic [NUM_READ-1:0]             rd_gnt_o,
  output logic [NUM_READ-1:0]             rd_rvalid_o,
  output logic [DATA_WIDTH-1:0]           rd_rdata_o,
  output logic                            rd_err_o,
  input  logic [NUM_WRITE-1:0]            wr_req_i,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data_i,
  output logic [NUM_WRITE-1:0]            wr_gnt_o,
  output logic [NUM_WRITE-1:0]            wr_done_o,
  output logic                            wr_err_o,
  output logic                            idle_o,
  output logic [ADDR_WIDTH-1:0]           m_aw_addr_o,
  output logic                            m_aw_valid_o,
  input  logic                            m_aw_ready_i,
  output logic [DATA_WIDTH-1:0]           m_w_data_o,
  output logic [DATA_WIDTH/8-1:0]         m_w_strb_o,
  output logic                            m_w_valid_o,
  input  logic                            m_w_ready_i,
  input  logic [1:0]                      m_b_resp_i,
  input  logic                            m_b_valid_i,
  output logic                            m_b_ready_o,
  output logic [ADDR_WIDTH-1:0]           m_ar_addr_o,
  output logic                            m_ar_valid_o,
  input  logic                            m_ar_ready_i,
  input  logic [DATA_WIDTH-1:0]           m_r_data_i,
  input  logic [1:0]                      m_r_resp_i,
  input  logic                            m_r_valid_i,
  output logic                            m_r_ready_o
);

  localparam int TOTAL = NUM_READ + NUM_WRITE;
  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD_AR  = 3'd1;
  localparam logic [2:0] ST_RD_R   = 3'd2;
  localparam logic [2:0] ST_WR_AWW = 3'd3;
  localparam logic [2:0] ST_WR_B   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [IDX_W-1:0]      id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  aw_valid_q, aw_valid_d;
  logic                  w_valid_q, w_valid_d;
  logic [NUM_READ-1:0]   rd_rvalid_q, rd_rvalid_d;
  logic                  rd_err_q, rd_err_d;
  logic [NUM_WRITE-1:0]  wr_done_q, wr_done_d;
  logic                  wr_err_q, wr_err_d;

  logic [TOTAL-1:0]      req_all;
  logic                  win_found;
  logic [IDX_W-1:0]      win_idx;
  logic                  win_is_wr;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;

  assign req_all = {wr_req_i, rd_req_i};

  // Writes sit above reads in one index space; search starts just past the last winner.
  always_comb begin
    int         cand;
    logic [IDX_W-1:0] cand_idx;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cand      = 0;
    cand_idx  = '0;
    win_found = 1'b0;
    win_idx   = last_q;
    for (int off = 1; off <= TOTAL; off++) begin
      cand     = (int'(last_q) + off) % TOTAL;
      cand_idx = IDX_W'(cand);
      if (!win_found && req_all[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    win_addr  = '0;
    win_data  = '0;
    win_is_wr = (int'(win_idx) >= NUM_READ);
    for (int i = 0; i < NUM_READ; i++) begin
      if (win_idx == IDX_W'(i)) win_addr = rd_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (win_idx == IDX_W'(NUM_READ + j)) begin
        win_addr = wr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
        win_data = wr_data_i[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    aw_valid_d  = aw_valid_q;
    w_valid_d   = w_valid_q;
    rd_rvalid_d = '0;
    rd_err_d    = 1'b0;
    wr_done_d   = '0;
    wr_err_d    = 1'b0;
    rd_gnt_o    = '0;
    wr_gnt_o    = '0;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          last_d = win_idx;
          id_d   = win_idx;
          addr_d = win_addr;
          for (int i = 0; i < NUM_READ; i++)  rd_gnt_o[i] = (win_idx == IDX_W'(i));
          for (int j = 0; j < NUM_WRITE; j++) wr_gnt_o[j] = (win_idx == IDX_W'(NUM_READ + j));
          if (win_is_wr) begin
            wdata_d    = win_data;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            state_d    = ST_WR_AWW;
          end else begin
            state_d = ST_RD_AR;
          end
        end
      end
      ST_RD_AR: begin
        if (m_ar_ready_i) state_d = ST_RD_R;
      end
      ST_RD_R: begin
        if (m_r_valid_i) begin
          rdata_d  = m_r_data_i;
          rd_err_d = m_r_resp_i[1];
          for (int i = 0; i < NUM_READ; i++) rd_rvalid_d[i] = (id_q == IDX_W'(i));
          state_d  = ST_IDLE;
        end
      end
      ST_WR_AWW: begin
        // AW and W retire independently; leave once neither is still pending.
        if (m_aw_ready_i) aw_valid_d = 1'b0;
        if (m_w_ready_i)  w_valid_d  = 1'b0;
        if (!aw_valid_d && !w_valid_d) state_d = ST_WR_B;
      end
      ST_WR_B: begin
        if (m_b_valid_i) begin
          wr_err_d = m_b_resp_i[1];
          for (int j = 0; j < NUM_WRITE; j++) wr_done_d[j] = (id_q == IDX_W'(NUM_READ + j));
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      last_q      <= IDX_W'(TOTAL - 1);
      id_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      rd_rvalid_q <= '0;
      rd_err_q    <= 1'b0;
      wr_done_q   <= '0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      rd_rvalid_q <= rd_rvalid_d;
      rd_err_q    <= rd_err_d;
      wr_done_q   <= wr_done_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign idle_o       = (state_q == ST_IDLE);
  assign m_ar_valid_o = (state_q == ST_RD_AR);
  assign m_ar_addr_o  = addr_q;
  assign m_r_ready_o  = (state_q == ST_RD_R);
  assign m_aw_valid_o = aw_valid_q;
  assign m_aw_addr_o  = addr_q;
  assign m_w_valid_o  = w_valid_q;
  assign m_w_data_o   = wdata_q;
  assign m_w_strb_o   = '1;
  assign m_b_ready_o  = (state_q == ST_WR_B);
  assign rd_rvalid_o  = rd_rvalid_q;
  assign rd_rdata_o   = rdata_q;
  assign rd_err_o     = rd_err_q;
  assign wr_done_o    = wr_done_q;
  assign wr_err_o     = wr_err_q;

  // Only the error bit of each response matters; OKAY vs EXOKAY is irrelevant here.
  logic unused_resp;
  assign unused_resp = m_b_resp_i[0] ^ m_r_resp_i[0];

endmodule
